// File: rtl/seven_seg_scanner_if.sv
// Pin bundle for the seven-segment scanner.
// Digit/control inputs flow master->slave; display pins flow back.
interface seven_seg_scanner_if;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic [3:0] dp_mask;
  logic [3:0] brightness;
  logic       blank_leading;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output digit3, digit2, digit1, digit0,
    output dp_mask, brightness, blank_leading,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  digit3, digit2, digit1, digit0,
    input  dp_mask, brightness, blank_leading,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// 4-digit multiplexed seven-segment driver with frame snapshot,
// leading-zero blanking and 16-level PWM brightness.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic rst,
  seven_seg_scanner_if.slave bus
);
  localparam int SUB = REFRESH_DIV / 16;
  localparam int CW  = $clog2(REFRESH_DIV);
  localparam int PW  = (SUB > 1) ? $clog2(SUB) : 1;

  logic [CW-1:0]   slot_cnt;
  logic [PW-1:0]   sub_cnt;
  logic [3:0]      phase;
  logic [1:0]      idx;
  logic            slot_end;
  logic            sub_end;
  logic            frame_end;

  logic [3:0][3:0] dig_snap;
  logic [3:0]      dpm_snap;
  logic [3:0]      bri_snap;
  logic            bl_snap;

  logic [3:0]      cur;
  logic [6:0]      glyph;
  logic            lit;
  logic            blank;
  logic [3:0]      an_d;
  logic [6:0]      seg_d;
  logic            dp_d;

  assign slot_end  = slot_cnt == CW'(REFRESH_DIV - 1);
  assign sub_end   = sub_cnt == PW'(SUB - 1);
  assign frame_end = slot_end && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      sub_cnt  <= '0;
      phase    <= '0;
      idx      <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      sub_cnt  <= '0;
      phase    <= '0;
      idx      <= idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
      if (sub_end) begin
        sub_cnt <= '0;
        phase   <= phase + 4'd1;
      end else begin
        sub_cnt <= sub_cnt + PW'(1);
      end
    end
  end

  // Inputs are only sampled at the frame boundary to avoid tearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_snap <= '0;
      dpm_snap <= '0;
      bri_snap <= '0;
      bl_snap  <= 1'b0;
    end else if (frame_end) begin
      dig_snap <= {bus.digit3, bus.digit2,
                   bus.digit1, bus.digit0};
      dpm_snap <= bus.dp_mask;
      bri_snap <= bus.brightness;
      bl_snap  <= bus.blank_leading;
    end
  end

  always_comb begin
    cur   = dig_snap[idx];
    lit   = (phase != 4'd0) && (phase <= bri_snap);
    blank = bl_snap && (idx == 2'd3) && (cur == 4'd0);
    glyph = 7'b1111111;
    case (cur)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = blank ? 7'h7F : glyph;
      dp_d  = ~dpm_snap[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an         <= 4'hF;
      bus.seg        <= 7'h7F;
      bus.dp         <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.an         <= an_d;
      bus.seg        <= seg_d;
      bus.dp         <= dp_d;
      bus.frame_tick <= frame_end;
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: position-based reference model,
// vector table per frame, and reset/snapshot sequences.
module tb_seven_seg_scanner;
  localparam int RD    = 32;
  localparam int SUBC  = RD / 16;
  localparam int FRAME = 4 * RD;

  typedef struct {
    logic [3:0][3:0] dig;
    logic [3:0]      dpm;
    logic [3:0]      br;
    logic            bl;
    logic [3:0][6:0] segs;
    int              on;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seven_seg_scanner_if bus();

  seven_seg_scanner #(.REFRESH_DIV(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_tab [16];

  int              k = 0;
  logic [3:0][3:0] q_d;
  logic [3:0]      q_dpm;
  logic [3:0]      q_br;
  logic            q_bl;
  logic [3:0]      m_d [4];
  logic [3:0]      m_dpm;
  logic [3:0]      m_br;
  logic            m_bl;
  int              p_m, ix_m, ph_m;
  logic            lt_m;
  logic [3:0]      e_an;
  logic [6:0]      e_seg;
  logic            e_dp, e_ft;

  // Edge counter since reset and the inputs present at each edge.
  always @(posedge clk) begin
    if (rst) k <= 0;
    else k <= k + 1;
    q_d   <= {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    q_dpm <= bus.dp_mask;
    q_br  <= bus.brightness;
    q_bl  <= bus.blank_leading;
  end

  // Pins after edge k show frame position (k-1) mod FRAME.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
      m_dpm = '0;
      m_br  = '0;
      m_bl  = 1'b0;
    end else if (k > 0) begin
      p_m  = (k - 1) % FRAME;
      ix_m = p_m / RD;
      ph_m = (p_m % RD) / SUBC;
      lt_m = (ph_m >= 1) && (ph_m <= int'(m_br));
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (lt_m) begin
        e_an = ~(4'b0001 << ix_m);
        e_dp = ~m_dpm[ix_m];
        if (!(m_bl && ix_m == 3 && m_d[3] == 4'd0))
          e_seg = dec_tab[m_d[ix_m]];
      end
      e_ft = (k % FRAME) == 0;
      checks++;
      if (bus.an !== e_an || bus.seg !== e_seg ||
          bus.dp !== e_dp || bus.frame_tick !== e_ft) begin
        errors++;
        $display("FAIL model k=%0d an=%b/%b seg=%b/%b dp=%b/%b ft=%b/%b",
                 k, bus.an, e_an, bus.seg, e_seg,
                 bus.dp, e_dp, bus.frame_tick, e_ft);
      end
      if ((k % FRAME) == 0) begin
        for (int i = 0; i < 4; i++) m_d[i] = q_d[i];
        m_dpm = q_dpm;
        m_br  = q_br;
        m_bl  = q_bl;
      end
    end
  end

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0][3:0] d,
                        input logic [3:0] dpm,
                        input logic [3:0] br,
                        input logic bl);
    bus.digit3        = d[3];
    bus.digit2        = d[2];
    bus.digit1        = d[1];
    bus.digit0        = d[0];
    bus.dp_mask       = dpm;
    bus.brightness    = br;
    bus.blank_leading = bl;
  endtask

  task automatic wait_tick(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_tick !== 1'b1 && n < lim);
    if (bus.frame_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout waited=%0d required=tick", n);
    end
  endtask

  vec_t vt [5];
  int   on_c [4];
  int   first_c [4];
  int   bad_c [4];
  int   n, s, off;

  initial begin
    dec_tab[0] = 7'b1000000; dec_tab[1] = 7'b1111001;
    dec_tab[2] = 7'b0100100; dec_tab[3] = 7'b0110000;
    dec_tab[4] = 7'b0011001; dec_tab[5] = 7'b0010010;
    dec_tab[6] = 7'b0000010; dec_tab[7] = 7'b1111000;
    dec_tab[8] = 7'b0000000; dec_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'b1111111;

    vt[0] = '{dig: {4'd1, 4'd2, 4'd3, 4'd4}, dpm: 4'b0010,
              br: 4'd15, bl: 1'b0,
              segs: {7'b1111001, 7'b0100100,
                     7'b0110000, 7'b0011001}, on: 30};
    vt[1] = '{dig: {4'd9, 4'd8, 4'd12, 4'd0}, dpm: 4'b0000,
              br: 4'd3, bl: 1'b1,
              segs: {7'b0010000, 7'b0000000,
                     7'b1111111, 7'b1000000}, on: 6};
    vt[2] = '{dig: {4'd0, 4'd7, 4'd6, 4'd5}, dpm: 4'b1001,
              br: 4'd8, bl: 1'b1,
              segs: {7'b1111111, 7'b1111000,
                     7'b0000010, 7'b0010010}, on: 16};
    vt[3] = '{dig: {4'd0, 4'd7, 4'd6, 4'd5}, dpm: 4'b0100,
              br: 4'd1, bl: 1'b0,
              segs: {7'b1000000, 7'b1111000,
                     7'b0000010, 7'b0010010}, on: 2};
    vt[4] = '{dig: {4'd1, 4'd2, 4'd3, 4'd4}, dpm: 4'b1111,
              br: 4'd0, bl: 1'b0,
              segs: {7'h7F, 7'h7F, 7'h7F, 7'h7F}, on: 0};

    set_in({4'd1, 4'd2, 4'd3, 4'd4}, 4'b0010, 4'd15, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_an", int'(bus.an), 15);
    check("rst_seg", int'(bus.seg), 127);
    check("rst_dp", int'(bus.dp), 1);
    check("rst_ft", int'(bus.frame_tick), 0);
    rst = 1'b0;
    wait_tick(3 * FRAME, n);
    check("first_tick", n, FRAME);

    for (int v = 0; v < 5; v++) begin
      set_in(vt[v].dig, vt[v].dpm, vt[v].br, vt[v].bl);
      wait_tick(2 * FRAME + 2, n);
      for (int i = 0; i < 4; i++) begin
        on_c[i] = 0;
        first_c[i] = -1;
        bad_c[i] = 0;
      end
      for (int j = 0; j < FRAME; j++) begin
        @(negedge clk);
        s = j / RD;
        off = j % RD;
        if (bus.an !== 4'hF) begin
          on_c[s]++;
          if (first_c[s] < 0) first_c[s] = off;
          if (bus.an !== ~(4'b0001 << s) ||
              bus.seg !== vt[v].segs[s] ||
              bus.dp !== ~vt[v].dpm[s])
            bad_c[s]++;
        end else if (bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
          bad_c[s]++;
        end
      end
      for (int i = 0; i < 4; i++) begin
        check($sformatf("v%0d_on%0d", v, i), on_c[i], vt[v].on);
        check($sformatf("v%0d_start%0d", v, i), first_c[i],
              (vt[v].on == 0) ? -1 : 2);
        check($sformatf("v%0d_pins%0d", v, i), bad_c[i], 0);
      end
    end

    set_in({4'd0, 4'd0, 4'd0, 4'd5}, 4'b0000, 4'd15, 1'b0);
    wait_tick(2 * FRAME + 2, n);
    repeat (11) @(negedge clk);
    check("snap_before", int'(bus.seg), int'(7'b0010010));
    bus.digit0 = 4'd7;
    repeat (10) @(negedge clk);
    check("snap_hold", int'(bus.seg), int'(7'b0010010));
    wait_tick(2 * FRAME, n);
    check("tick_spacing", n + 21, FRAME);
    repeat (11) @(negedge clk);
    check("snap_after", int'(bus.seg), int'(7'b1111000));

    n = 0;
    while (bus.an !== 4'b1110 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_an", int'(bus.an), 14);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_an", int'(bus.an), 15);
    check("mid_rst_seg", int'(bus.seg), 127);
    check("mid_rst_dp", int'(bus.dp), 1);
    check("mid_rst_ft", int'(bus.frame_tick), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_tick(3 * FRAME, n);
    check("post_rst_tick", n, FRAME);

    for (int r = 0; r < 20 * FRAME; r++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0)
        set_in({4'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom)},
               4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
